// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared lane state encoding and occupancy width helper
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_AB = 3'd5,
    EX_A  = 3'd6,
    FAULT = 3'd7
  } lane_state_e;

  function automatic int occ_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// rtl/parking_lane_fsm.sv - one lane's direction decoder with dwell timeout
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_a_i,
  input  logic sens_b_i,
  output logic enter_o,
  output logic exit_o,
  output logic fault_o
);

  localparam int DW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lane_state_e   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          enter_q, enter_d;
  logic          exit_q, exit_d;
  logic          fault_q, fault_d;
  logic [1:0]    ab;

  assign ab = {sens_a_i, sens_b_i};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  case (ab)
               2'b00:   state_d = IDLE;
               2'b10:   state_d = EN_A;
               2'b01:   state_d = EX_B;
               default: state_d = FAULT;
             endcase
      EN_A:  case (ab)
               2'b10:   state_d = EN_A;
               2'b11:   state_d = EN_AB;
               2'b00:   state_d = IDLE;
               default: state_d = FAULT;
             endcase
      EN_AB: case (ab)
               2'b11:   state_d = EN_AB;
               2'b01:   state_d = EN_B;
               2'b10:   state_d = EN_A;
               default: state_d = FAULT;
             endcase
      EN_B:  case (ab)
               2'b01:   state_d = EN_B;
               2'b11:   state_d = EN_AB;
               2'b00:   state_d = IDLE;
               default: state_d = FAULT;
             endcase
      EX_B:  case (ab)
               2'b01:   state_d = EX_B;
               2'b11:   state_d = EX_AB;
               2'b00:   state_d = IDLE;
               default: state_d = FAULT;
             endcase
      EX_AB: case (ab)
               2'b11:   state_d = EX_AB;
               2'b10:   state_d = EX_A;
               2'b01:   state_d = EX_B;
               default: state_d = FAULT;
             endcase
      EX_A:  case (ab)
               2'b10:   state_d = EX_A;
               2'b11:   state_d = EX_AB;
               2'b00:   state_d = IDLE;
               default: state_d = FAULT;
             endcase
      // Recovery: a faulted lane waits for both beams to clear.
      FAULT:   state_d = (ab == 2'b00) ? IDLE : FAULT;
      default: state_d = FAULT;
    endcase

    if (TIMEOUT != 0 && state_q != IDLE && state_q != FAULT && dwell_q == DWELL_LAST) begin
      state_d = FAULT;
    end

    enter_d = (state_q == EN_B) && (state_d == IDLE);
    exit_d  = (state_q == EX_A) && (state_d == IDLE);
    fault_d = (state_d == FAULT) && (state_q != FAULT);

    if (TIMEOUT == 0 || state_q == IDLE || state_q == FAULT ||
        state_d == IDLE || state_d == FAULT) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dwell_q <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      fault_q <= fault_d;
    end
  end

  assign enter_o = enter_q;
  assign exit_o  = exit_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/parking_lot_ctrl.sv
// rtl/parking_lot_ctrl.sv - multi-lane parking controller with clamped occupancy count
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CAPACITY  = 64,
  parameter int TIMEOUT   = 1024,
  localparam int CW       = occ_width(CAPACITY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] sens_a,
  input  logic [NUM_LANES-1:0] sens_b,
  input  logic                 clear,
  output logic [NUM_LANES-1:0] enter_pulse,
  output logic [NUM_LANES-1:0] exit_pulse,
  output logic [NUM_LANES-1:0] fault,
  output logic [CW-1:0]        occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  output logic                 unf
);

  localparam logic signed [CW+3:0] CAP_S = (CW+4)'(CAPACITY);
  localparam logic [CW-1:0]        CAP_U = CW'(CAPACITY);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    parking_lane_fsm #(
      .TIMEOUT(TIMEOUT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .sens_a_i (sens_a[g]),
      .sens_b_i (sens_b[g]),
      .enter_o  (enter_pulse[g]),
      .exit_o   (exit_pulse[g]),
      .fault_o  (fault[g])
    );
  end

  logic signed [CW+3:0] cnt_e, cnt_x, raw;
  logic [CW-1:0]        occ_q, occ_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  // Entries and exits net out before clamping, so a full lot with one in and one out is untouched.
  always_comb begin
    cnt_e = '0;
    cnt_x = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_e = cnt_e + {{(CW+3){1'b0}}, enter_pulse[i]};
      cnt_x = cnt_x + {{(CW+3){1'b0}}, exit_pulse[i]};
    end
    raw   = $signed({4'b0000, occ_q}) + cnt_e - cnt_x;
    occ_d = raw[CW-1:0];
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      occ_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (raw > CAP_S) begin
      occ_d = CAP_U;
      ovf_d = 1'b1;
    end else if (raw[CW+3]) begin
      occ_d = '0;
      unf_d = 1'b1;
    end
    full_d  = (occ_d == CAP_U);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb/tb_parking_lot_ctrl.sv - directed self-checking bench for parking_lot_ctrl
module tb_parking_lot_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] sens_a, sens_b;
  logic       clear;
  logic [1:0] enter_pulse, exit_pulse, fault;
  logic [2:0] occupancy;
  logic       full, empty, ovf, unf;

  int checks = 0;
  int errors = 0;
  logic [1:0] seen;

  parking_lot_ctrl #(
    .NUM_LANES (2),
    .CAPACITY  (4),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sens_a      (sens_a),
    .sens_b      (sens_b),
    .clear       (clear),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .fault       (fault),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .ovf         (ovf),
    .unf         (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] a, input logic [1:0] b);
    sens_a = a;
    sens_b = b;
    @(posedge clk);
    #1;
  endtask

  // Drives ab = 10,11,01,00 on every lane set in m.
  task automatic entry(input logic [1:0] m);
    cyc(m, 2'b00);
    cyc(m, m);
    cyc(2'b00, m);
    cyc(2'b00, 2'b00);
  endtask

  // Drives ab = 01,11,10,00 on every lane set in m.
  task automatic leave(input logic [1:0] m);
    cyc(2'b00, m);
    cyc(m, m);
    cyc(m, 2'b00);
    cyc(2'b00, 2'b00);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; sens_a = '0; sens_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(2'b00, 2'b00);
    chk("rst_occ", occupancy, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_pulses", {fault, exit_pulse, enter_pulse}, 0);

    entry(2'b01);
    chk("entry0_pulse", enter_pulse, 2'b01);
    chk("entry0_occ_lag", occupancy, 0);
    cyc(2'b00, 2'b00);
    chk("entry0_pulse_end", enter_pulse, 2'b00);
    chk("entry0_occ", occupancy, 1);
    chk("entry0_empty", empty, 0);

    leave(2'b10);
    chk("exit1_pulse", exit_pulse, 2'b10);
    cyc(2'b00, 2'b00);
    chk("exit1_occ", occupancy, 0);
    chk("exit1_empty", empty, 1);
    chk("exit1_unf", unf, 0);
    leave(2'b10);
    cyc(2'b00, 2'b00);
    chk("unf_occ", occupancy, 0);
    chk("unf_set", unf, 1);

    clear = 1'b1;
    cyc(2'b00, 2'b00);
    clear = 1'b0;
    chk("clear_unf", unf, 0);

    entry(2'b11);
    chk("dual_entry_pulse", enter_pulse, 2'b11);
    cyc(2'b00, 2'b00);
    chk("dual_entry_occ", occupancy, 2);
    entry(2'b11);
    cyc(2'b00, 2'b00);
    chk("fill_occ", occupancy, 4);
    chk("fill_full", full, 1);
    chk("fill_ovf", ovf, 0);

    entry(2'b01);
    cyc(2'b00, 2'b00);
    chk("ovf_occ", occupancy, 4);
    chk("ovf_set", ovf, 1);
    chk("ovf_full", full, 1);

    clear = 1'b1;
    cyc(2'b00, 2'b00);
    clear = 1'b0;
    chk("clear_occ", occupancy, 0);
    chk("clear_ovf", ovf, 0);
    entry(2'b11);
    cyc(2'b00, 2'b00);
    entry(2'b11);
    cyc(2'b00, 2'b00);
    cyc(2'b01, 2'b10);
    cyc(2'b11, 2'b11);
    cyc(2'b10, 2'b01);
    cyc(2'b00, 2'b00);
    chk("net_enter", enter_pulse, 2'b01);
    chk("net_exit", exit_pulse, 2'b10);
    cyc(2'b00, 2'b00);
    chk("net_occ", occupancy, 4);
    chk("net_ovf", ovf, 0);
    chk("net_full", full, 1);

    clear = 1'b1;
    cyc(2'b00, 2'b00);
    clear = 1'b0;
    cyc(2'b01, 2'b01);
    chk("fault11_pulse", fault, 2'b01);
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      cyc(2'b01, 2'b01);
      seen = seen | fault | enter_pulse | exit_pulse;
    end
    chk("fault_hold_quiet", seen, 2'b00);
    cyc(2'b00, 2'b00);
    cyc(2'b00, 2'b00);
    chk("fault_recover_pulses", {fault, exit_pulse, enter_pulse}, 0);
    chk("fault_occ", occupancy, 0);

    seen = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(2'b01, 2'b00);
      seen = seen | fault;
    end
    chk("timeout_early", seen, 2'b00);
    cyc(2'b01, 2'b00);
    chk("timeout_fault", fault, 2'b01);
    cyc(2'b01, 2'b00);
    chk("timeout_fault_end", fault, 2'b00);
    cyc(2'b00, 2'b00);
    entry(2'b01);
    chk("after_timeout_enter", enter_pulse, 2'b01);
    cyc(2'b00, 2'b00);
    chk("after_timeout_occ", occupancy, 1);

    cyc(2'b01, 2'b00);
    cyc(2'b01, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_occ", occupancy, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_full", full, 0);
    #1 rst = 1'b0;
    seen = '0;
    cyc(2'b00, 2'b01);
    seen = seen | enter_pulse | exit_pulse | fault;
    cyc(2'b00, 2'b00);
    seen = seen | enter_pulse | exit_pulse | fault;
    cyc(2'b00, 2'b00);
    seen = seen | enter_pulse | exit_pulse | fault;
    chk("post_rst_no_pulse", seen, 2'b00);
    chk("post_rst_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
